// File: rtl/fg_cfg_pkg.sv
// Shared constants, field layout and FSM state type for the configuration loader.
package fg_cfg_pkg;

    localparam int CFG_BYTES = 7;
    localparam int CFG_W     = 56;

    localparam int CONSTANT_BIT  = 55;
    localparam int MODULATED_BIT = 54;
    localparam int PRESCALER_LSB = 48;
    localparam int PRESCALER_W   = 6;
    localparam int COUNTER_LSB   = 40;
    localparam int PHASE_LSB     = 32;
    localparam int RISE_LSB      = 24;
    localparam int FALL_LSB      = 16;
    localparam int AMP_LSB       = 8;
    localparam int OFFSET_LSB    = 0;
    localparam int FIELD8_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_e;

    // Address 0 lands in the most significant byte of the shadow word.
    function automatic int byte_lsb(input logic [2:0] addr);
        return 8 * (CFG_BYTES - 1 - int'(addr));
    endfunction

endpackage

// File: rtl/fg_sync.sv
// Generic N-stage synchroniser whose flops reset to a chosen idle level.
module fg_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fg_cfg_loader.sv
// Host byte-bus front-end: assembles a 56-bit shadow word and commits it
// atomically to the active configuration only when a session wrote all bytes.
module fg_cfg_loader
    import fg_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EN_BIT      = 7,
    parameter int WR_BIT      = 6,
    parameter int ADDR_LSB    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             ui_in,
    input  logic [7:0]             uio_in,
    output logic                   cfg_constant,
    output logic                   cfg_modulated,
    output logic [PRESCALER_W-1:0] cfg_prescaler,
    output logic [FIELD8_W-1:0]    cfg_counter,
    output logic [FIELD8_W-1:0]    cfg_phase,
    output logic [FIELD8_W-1:0]    cfg_rise,
    output logic [FIELD8_W-1:0]    cfg_fall,
    output logic [FIELD8_W-1:0]    cfg_amplitude,
    output logic [FIELD8_W-1:0]    cfg_offset,
    output logic                   cfg_update,
    output logic                   cfg_busy,
    output logic                   cfg_error
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic en_s;
    logic wr_s;

    fg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_en_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[EN_BIT]),
        .q     (en_s)
    );

    fg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[WR_BIT]),
        .q     (wr_s)
    );

    cfg_state_e           state_q, state_d;
    logic                 en_prev_q, en_prev_d;
    logic                 wr_prev_q, wr_prev_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 armed_q, armed_d;
    logic [CFG_W-1:0]     shadow_q, shadow_d;
    logic [CFG_W-1:0]     active_q, active_d;
    logic [CFG_BYTES-1:0] written_q, written_d;
    logic                 update_q, update_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    logic       fill_done;
    logic       en_rise;
    logic       en_fall;
    logic       wr_rise;
    logic [2:0] addr;

    assign addr      = uio_in[ADDR_LSB +: 3];
    assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));
    // A session may only open after EN has been seen low with real (post-reset) samples.
    assign en_rise   = en_s & ~en_prev_q & armed_q;
    assign en_fall   = ~en_s & en_prev_q;
    assign wr_rise   = wr_s & ~wr_prev_q;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        written_d = written_q;
        update_d  = 1'b0;
        error_d   = error_q;
        en_prev_d = en_s;
        wr_prev_d = wr_s;
        fill_d    = fill_done ? fill_q : fill_q + FILL_W'(1);
        armed_d   = armed_q | (fill_done & ~en_s);

        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d   = LOAD;
                    written_d = '0;
                    error_d   = 1'b0;
                end
            end
            LOAD: begin
                if (wr_rise && addr != 3'd7) begin
                    shadow_d[byte_lsb(addr) +: 8] = ui_in;
                    written_d[addr]               = 1'b1;
                end
                if (en_fall) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (written_q == {CFG_BYTES{1'b1}}) begin
                    active_d = shadow_q;
                    update_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_prev_q <= 1'b0;
            wr_prev_q <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            written_q <= '0;
            update_q  <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            wr_prev_q <= wr_prev_d;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            written_q <= written_d;
            update_q  <= update_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    assign cfg_constant  = active_q[CONSTANT_BIT];
    assign cfg_modulated = active_q[MODULATED_BIT];
    assign cfg_prescaler = active_q[PRESCALER_LSB +: PRESCALER_W];
    assign cfg_counter   = active_q[COUNTER_LSB +: FIELD8_W];
    assign cfg_phase     = active_q[PHASE_LSB +: FIELD8_W];
    assign cfg_rise      = active_q[RISE_LSB +: FIELD8_W];
    assign cfg_fall      = active_q[FALL_LSB +: FIELD8_W];
    assign cfg_amplitude = active_q[AMP_LSB +: FIELD8_W];
    assign cfg_offset    = active_q[OFFSET_LSB +: FIELD8_W];
    assign cfg_update    = update_q;
    assign cfg_busy      = busy_q;
    assign cfg_error     = error_q;

    logic unused_uio;
    assign unused_uio = ^uio_in;

endmodule

// File: tb/tb_fg_cfg_loader.sv
// Self-checking bench: host-protocol sessions against a transaction-level model.
module tb_fg_cfg_loader;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic       en_r, wr_r;
    logic [2:0] addr_r, junk_r;
    logic [7:0] uio_in;

    logic       cfg_constant, cfg_modulated, cfg_update, cfg_busy, cfg_error;
    logic [5:0] cfg_prescaler;
    logic [7:0] cfg_counter, cfg_phase, cfg_rise, cfg_fall, cfg_amplitude, cfg_offset;

    assign uio_in = {en_r, wr_r, addr_r, junk_r};

    always #25 clk = ~clk;

    fg_cfg_loader #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ui_in         (ui_in),
        .uio_in        (uio_in),
        .cfg_constant  (cfg_constant),
        .cfg_modulated (cfg_modulated),
        .cfg_prescaler (cfg_prescaler),
        .cfg_counter   (cfg_counter),
        .cfg_phase     (cfg_phase),
        .cfg_rise      (cfg_rise),
        .cfg_fall      (cfg_fall),
        .cfg_amplitude (cfg_amplitude),
        .cfg_offset    (cfg_offset),
        .cfg_update    (cfg_update),
        .cfg_busy      (cfg_busy),
        .cfg_error     (cfg_error)
    );

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int exp_upd = 0;

    // Reference model: bytes held by the host-visible shadow, per-session coverage.
    logic [7:0]  m_bytes [7];
    bit          m_seen  [7];
    logic [55:0] m_active;
    bit          m_error;
    bit          m_open;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) upd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] dut_word();
        return {cfg_constant, cfg_modulated, cfg_prescaler, cfg_counter, cfg_phase,
                cfg_rise, cfg_fall, cfg_amplitude, cfg_offset};
    endfunction

    function automatic logic [55:0] model_pack();
        logic [55:0] w;
        for (int i = 0; i < 7; i++) w[8*(6-i) +: 8] = m_bytes[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_bytes[i] = 8'h00;
            m_seen[i]  = 1'b0;
        end
        m_active = '0;
        m_error  = 1'b0;
        m_open   = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        if (m_open && a != 3'd7) begin
            m_bytes[a] = d;
            m_seen[a]  = 1'b1;
        end
    endtask

    task automatic model_commit();
        bit all;
        if (!m_open) return;
        all = 1'b1;
        for (int i = 0; i < 7; i++) all &= m_seen[i];
        if (all) begin
            m_active = model_pack();
            exp_upd++;
        end else begin
            m_error = 1'b1;
        end
        m_open = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_word"}, dut_word(), m_active);
        check_eq({tag, "_err"}, cfg_error, m_error);
        check_eq({tag, "_upd"}, upd_cnt, exp_upd);
    endtask

    task automatic open_session();
        en_r = 1'b1;
        wait_cycles(6);
        m_open = 1'b1;
        m_error = 1'b0;
        for (int i = 0; i < 7; i++) m_seen[i] = 1'b0;
    endtask

    task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
        addr_r = a;
        ui_in  = d;
        junk_r = 3'($urandom);
        wr_r   = 1'b0;
        wait_cycles(4);
        wr_r = 1'b1;
        wait_cycles(5);
        model_write(a, d);
    endtask

    task automatic close_session();
        en_r = 1'b0;
        wait_cycles(8);
        model_commit();
    endtask

    // Final byte with EN dropped at the same instant; returns edges until cfg_update.
    task automatic write_and_close(input logic [2:0] a, input logic [7:0] d, output int lat);
        addr_r = a;
        ui_in  = d;
        wr_r   = 1'b0;
        wait_cycles(4);
        wr_r = 1'b1;
        en_r = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (cfg_update === 1'b1) begin
                lat = k;
                break;
            end
        end
        wait_cycles(6);
        model_write(a, d);
        model_commit();
    endtask

    task automatic full_session(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        open_session();
        write_byte(3'd0, b0);
        write_byte(3'd1, b1);
        write_byte(3'd2, b2);
        write_byte(3'd3, b3);
        write_byte(3'd4, b4);
        write_byte(3'd5, b5);
        write_byte(3'd6, b6);
        close_session();
    endtask

    initial begin
        int lat;
        logic [55:0] trap_word;
        trap_word = 56'h14_63_32_05_0A_64_0A;
        model_reset();
        rst_n  = 1'b0;
        en_r   = 1'b0;
        wr_r   = 1'b1;
        addr_r = 3'd0;
        junk_r = 3'd0;
        ui_in  = 8'h00;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);
        check_eq("rst_word", dut_word(), 56'h0);
        check_eq("rst_busy", cfg_busy, 1'b0);
        check_eq("rst_err", cfg_error, 1'b0);
        wait_cycles(10);
        check_eq("idle_upd", upd_cnt, 0);

        // Trapezoid
        open_session();
        check_eq("busy_open", cfg_busy, 1'b1);
        write_byte(3'd0, 8'h14); write_byte(3'd1, 8'h63); write_byte(3'd2, 8'h32);
        write_byte(3'd3, 8'h05); write_byte(3'd4, 8'h0A); write_byte(3'd5, 8'h64);
        write_byte(3'd6, 8'h0A);
        close_session();
        check_eq("busy_idle", cfg_busy, 1'b0);
        check_state("trap");
        check_eq("trap_presc", cfg_prescaler, 20);
        check_eq("trap_cnt", cfg_counter, 99);
        check_eq("trap_phase", cfg_phase, 50);
        check_eq("trap_rise", cfg_rise, 5);
        check_eq("trap_fall", cfg_fall, 10);
        check_eq("trap_amp", cfg_amplitude, 100);
        check_eq("trap_off", cfg_offset, 10);
        check_eq("trap_cm", {cfg_constant, cfg_modulated}, 2'b00);

        // Constant
        full_session(8'h94, 8'hC8, 8'h40, 8'h04, 8'h04, 8'h64, 8'hF6);
        check_state("const");
        check_eq("const_c", cfg_constant, 1'b1);
        check_eq("const_presc", cfg_prescaler, 20);
        check_eq("const_cnt", cfg_counter, 200);
        check_eq("const_off", cfg_offset, 8'hF6);

        // Trapezoid again, then incomplete sine
        full_session(8'h14, 8'h63, 8'h32, 8'h05, 8'h0A, 8'h64, 8'h0A);
        open_session();
        write_byte(3'd0, 8'h68); write_byte(3'd1, 8'h06); write_byte(3'd2, 8'h40);
        write_byte(3'd3, 8'h00); write_byte(3'd4, 8'h00); write_byte(3'd5, 8'h32);
        close_session();
        check_state("partial");
        check_eq("partial_err", cfg_error, 1'b1);
        check_eq("partial_keep", dut_word(), trap_word);

        open_session();
        check_eq("err_clr", cfg_error, 1'b0);
        write_byte(3'd0, 8'h68); write_byte(3'd1, 8'h06); write_byte(3'd2, 8'h40);
        write_byte(3'd3, 8'h00); write_byte(3'd4, 8'h00); write_byte(3'd5, 8'h32);
        write_byte(3'd6, 8'h00);
        close_session();
        check_state("sine");
        check_eq("sine_mod", cfg_modulated, 1'b1);
        check_eq("sine_presc", cfg_prescaler, 40);
        check_eq("sine_cnt", cfg_counter, 6);
        check_eq("sine_amp", cfg_amplitude, 50);

        // Address 7 and duplicate address 3
        open_session();
        write_byte(3'd0, 8'h14); write_byte(3'd1, 8'h63); write_byte(3'd3, 8'h01);
        write_byte(3'd7, 8'hFF); write_byte(3'd2, 8'h32); write_byte(3'd3, 8'h05);
        write_byte(3'd4, 8'h0A); write_byte(3'd5, 8'h64); write_byte(3'd6, 8'h0A);
        close_session();
        check_state("a7dup");
        check_eq("a7dup_rise", cfg_rise, 5);
        check_eq("a7dup_word", dut_word(), trap_word);

        // Final byte coincident with EN fall
        open_session();
        write_byte(3'd0, 8'h94); write_byte(3'd1, 8'hC8); write_byte(3'd2, 8'h40);
        write_byte(3'd3, 8'h04); write_byte(3'd4, 8'h04); write_byte(3'd5, 8'h64);
        write_and_close(3'd6, 8'hF6, lat);
        check_eq("same_lat", lat, SYNC_STAGES + 2);
        check_state("same");
        check_eq("same_off", cfg_offset, 8'hF6);

        // Reset mid-session, EN kept high
        open_session();
        write_byte(3'd0, 8'h11); write_byte(3'd1, 8'h22);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        model_reset();
        wait_cycles(2);
        check_eq("mrst_word", dut_word(), 56'h0);
        check_eq("mrst_busy", cfg_busy, 1'b0);
        for (int i = 0; i < 7; i++) write_byte(3'(i), 8'(8'h30 + i));
        close_session();
        check_state("blocked");
        full_session(8'h68, 8'h06, 8'h40, 8'h00, 8'h00, 8'h32, 8'h00);
        check_state("rearm");

        // Randomised sessions
        for (int s = 0; s < 8; s++) begin
            int n;
            open_session();
            if (s % 2 == 0) begin
                for (int i = 0; i < 7; i++) write_byte(3'(i), 8'($urandom));
            end
            n = $urandom_range(2, 9);
            for (int i = 0; i < n; i++) write_byte(3'($urandom_range(0, 7)), 8'($urandom));
            close_session();
            check_state($sformatf("rnd%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fg_cfg_loader.md
# fg_cfg_loader

Configuration front-end of the function generator. It synchronises the slow byte-wide host bus (data on `ui_in`, address/enable/write strobe on `uio_in`) into the core clock domain and assembles seven bytes into a 56-bit shadow word. On a complete session it commits the word atomically to the active configuration that drives the waveform core directly downstream. A partial session never disturbs the running waveform.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flops in the EN/WR synchroniser chain; minimum 2.
- `EN_BIT`, 7, `uio_in` bit carrying session enable, active high.
- `WR_BIT`, 6, `uio_in` bit carrying the write strobe; a byte is taken on its rising edge.
- `ADDR_LSB`, 3, LSB of the 3-bit byte address in `uio_in`.

Ports:
- `clk` in 1: core clock (20 MHz nominal).
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `ui_in` in 8: configuration data byte.
- `uio_in` in 8: EN, WR and address[2:0]; all other bits are ignored.
- `cfg_constant` out 1: word bit 55.
- `cfg_modulated` out 1: word bit 54 (0 = wave, 1 = sine).
- `cfg_prescaler` out 6: bits 53..48.
- `cfg_counter` out 8: bits 47..40.
- `cfg_phase` out 8: bits 39..32 (phase / on-count).
- `cfg_rise` out 8: bits 31..24.
- `cfg_fall` out 8: bits 23..16.
- `cfg_amplitude` out 8: bits 15..8.
- `cfg_offset` out 8: bits 7..0, two's complement.
- `cfg_update` out 1: one-cycle pulse on the cycle the active fields change.
- `cfg_busy` out 1: high while a session is open (state LOAD).
- `cfg_error` out 1: sticky flag for an incomplete session; cleared when the next session opens.

## Operation
- EN and WR pass through a `SYNC_STAGES` synchroniser. An edge detector compares the last stage with one extra registered copy.
- `ui_in` and the address are not synchronised. The host holds them stable ≥200 ns around the WR rising edge, and they are sampled on the detect cycle.
- Byte address `a` in 0..6 writes `shadow[8*(6-a) +: 8]`, so address 0 is the MSB byte. Address 7 is ignored: no shadow write, no mask bit.
- The 7-bit `written` mask sets bit `a` on each accepted write. Rewriting an address overwrites the byte; the last write wins.
- FSM:
  - IDLE → LOAD on the synchronised EN rising edge. Clears `written` and `cfg_error`.
  - LOAD: WR rising edges are accepted.
  - LOAD → COMMIT on the EN falling edge.
  - COMMIT → IDLE unconditionally after 1 cycle.
- COMMIT with `written` = 7'h7F: the active registers load `shadow`, and `cfg_update` = 1 on the following cycle. Otherwise the active registers are unchanged, `cfg_error` is set and `cfg_update` stays 0.
- WR edges in IDLE or COMMIT are ignored.
- WR rising and EN falling detected in the same cycle: the byte is written first and counted in the mask, then COMMIT is evaluated with the updated mask.
- Shadow contents persist across sessions, but the mask does not. Every session must write all seven bytes.

## Timing
- Reset (rst_n low at a clk edge):
  - all active fields = 0, shadow = 0, mask = 0;
  - state IDLE;
  - `cfg_update`, `cfg_busy` and `cfg_error` = 0;
  - synchroniser flops load the idle levels EN = 0, WR = 1.
- Reset asserted mid-session discards the session. After release, a still-high EN is not treated as a rising edge; the host must drop EN and raise it again.
- Write latency: the shadow byte updates at clock edge `SYNC_STAGES+1` after the first edge that samples WR high.
- Commit latency: the state is COMMIT after edge `SYNC_STAGES+1` following the EN fall. The active fields and `cfg_update` change together at edge `SYNC_STAGES+2`.
- `cfg_busy` rises at edge `SYNC_STAGES+1` after EN rises.
- Active outputs are registered and glitch-free, and change only on a commit or a reset.
- Minimum host timing is WR low ≥ 3 and WR high ≥ 3 clk periods. The 200 ns/200 ns host protocol meets this at 20 MHz.

## Structure
- `fg_cfg_pkg` holds:
  - field bit positions and widths (55, 54, 53:48, …);
  - `CFG_BYTES` = 7 and `CFG_W` = 56;
  - the FSM state enum {IDLE, LOAD, COMMIT}.
- Sub-module `fg_sync`: a generic N-stage synchroniser with a reset value parameter, instantiated for EN and WR.
- The rest is flat, with the field slicing done by continuous assigns from the active 56-bit register.

## Test plan
- Reset with EN = 0, WR = 1 → all outputs 0. Hold 10 cycles: no `cfg_update`.
- Trapezoid session, bytes 0x14, 0x63, 0x32, 0x05, 0x0A, 0x64, 0x0A at addresses 0..6, then EN low →
  - one `cfg_update` pulse;
  - prescaler = 20, counter = 99, phase = 50, rise = 5, fall = 10, amp = 100, offset = 10;
  - `cfg_constant` = `cfg_modulated` = 0.
- Constant session, bytes 0x94, 0xC8, 0x40, 0x04, 0x04, 0x64, 0xF6 → `cfg_constant` = 1, prescaler = 20, counter = 200, offset = −10 (0xF6).
- Sine session after the trapezoid, sending only addresses 0..5 → `cfg_error` = 1, no pulse, trapezoid fields unchanged. A following full sine session (0x68, 0x06, 0x40, 0x00, 0x00, 0x32, 0x00) → `cfg_error` cleared, `cfg_modulated` = 1, prescaler = 40, counter = 6, amp = 50.
- Address-7 write of 0xFF mid-session plus a duplicate address 3 (0x01, then 0x05) → the full session commits with rise = 5 and no field affected by address 7.
- EN dropped in the same cycle as the final WR edge, and `rst_n` pulsed mid-session → final byte committed, with latency `SYNC_STAGES+2`. The reset returns all outputs to 0, and commit is blocked until EN is dropped and raised again.
